// File: rtl/timer_sched_pkg.sv
// Shared types and defaults for the timer slot scheduler.
package timer_sched_pkg;

    localparam int CNT_W_DEF = 32;
    localparam int NREQ_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/timer_slot_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter
    import timer_sched_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  win,
    output logic [IDX_W-1:0] win_idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Scan NREQ positions starting at the pointer; the first hit wins.
    always_comb begin
        found   = 1'b0;
        win     = '0;
        win_idx = '0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NREQ);
            if (!found && req[cand]) begin
                found        = 1'b1;
                win[cand]    = 1'b1;
                win_idx      = cand;
            end
        end
    end

endmodule

// File: rtl/timer_slot_scheduler.sv
// One shared down-counter time-multiplexed between NREQ requesters.
//
//  state | meaning
//  IDLE  | waiting for any request; arbitration happens here
//  LOAD  | winner's delay just loaded, gnt pulse visible
//  COUNT | counting down; abort returns to IDLE without done
//  DONE  | done pulse for cur_idx visible, pointer advances on exit
module timer_slot_scheduler
    import timer_sched_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic                  n0,
    input  logic                  n1,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*CNT_W-1:0] req_load,
    input  logic                  abort,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic [IDX_W-1:0]      cur_idx,
    output logic [CNT_W-1:0]      cnt_val
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NREQ-1:0]  done_q, done_d;
    logic             busy_q, busy_d;

    logic [NREQ-1:0]  arb_win;
    logic [IDX_W-1:0] arb_idx;
    logic [CNT_W-1:0] load_sel;
    logic [IDX_W-1:0] ptr_after;

    rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .win     (arb_win),
        .win_idx (arb_idx)
    );

    // Select the winner's delay with a one-hot mux and compute the next pointer.
    always_comb begin
        load_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_win[i]) load_sel = req_load[i*CNT_W +: CNT_W];
        end
        ptr_after = (idx_q == IDX_W'(NREQ - 1)) ? '0 : idx_q + IDX_W'(1);
    end

    // Next-state and next-output logic; all outputs are registered from these.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        gnt_d   = '0;
        done_d  = '0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = LOAD;
                    gnt_d   = arb_win;
                    idx_d   = arb_idx;
                    cnt_d   = load_sel;
                end
            end
            LOAD: state_d = COUNT;
            COUNT: begin
                // abort takes priority over expiry in the same cycle
                if (abort) begin
                    state_d = IDLE;
                    ptr_d   = ptr_after;
                end else if (cnt_q == '0) begin
                    state_d       = DONE;
                    done_d[idx_q] = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                ptr_d   = ptr_after;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge n0) begin
        if (n1) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign busy    = busy_q;
    assign cur_idx = idx_q;
    assign cnt_val = cnt_q;

endmodule

// File: tb/tb_timer_slot_scheduler.sv
// Bench for timer_slot_scheduler: directed scenarios plus a random phase,
// checked every cycle against a job-timeline model.
module tb_timer_slot_scheduler;

    localparam int NREQ  = 4;
    localparam int CNT_W = 32;

    logic                  n0 = 1'b0;
    logic                  n1 = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*CNT_W-1:0] req_load = '0;
    logic                  abort = 1'b0;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  busy;
    logic [1:0]            cur_idx;
    logic [CNT_W-1:0]      cnt_val;

    timer_slot_scheduler #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
        .n0(n0), .n1(n1), .req(req), .req_load(req_load), .abort(abort),
        .gnt(gnt), .done(done), .busy(busy), .cur_idx(cur_idx), .cnt_val(cnt_val)
    );

    always #5 n0 = ~n0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_seen = 0;
    int last_gnt_cyc = -1;
    int last_done_cyc = -1;
    bit auto_drop = 1'b1;

    // Job-timeline model: t = cycles since grant edge; job length is L+3 cycles.
    bit     m_active = 1'b0;
    longint m_t = 0;
    longint m_L = 0;
    int     m_cur = 0;
    int     m_ptr = 0;
    longint m_cnt = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic bound_expired(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: wait bound expired (cycle %0d)", tag, cyc);
    endtask

    function automatic logic [NREQ-1:0] exp_gnt();
        return (m_active && m_t == 0) ? NREQ'(1 << m_cur) : '0;
    endfunction

    function automatic logic [NREQ-1:0] exp_done();
        return (m_active && m_t == m_L + 2) ? NREQ'(1 << m_cur) : '0;
    endfunction

    task automatic model_edge();
        logic [CNT_W-1:0] lv;
        if (n1) begin
            m_active = 1'b0; m_ptr = 0; m_cnt = 0; m_cur = 0;
        end else if (m_active) begin
            if (m_t == 0) m_t = 1;
            else if (m_t <= m_L + 1) begin
                if (abort) begin m_active = 1'b0; m_ptr = (m_cur + 1) % NREQ; end
                else m_t++;
            end else begin
                m_active = 1'b0; m_ptr = (m_cur + 1) % NREQ;
            end
        end else if (req != '0) begin
            for (int k = 0; k < NREQ; k++) begin
                if (req[(m_ptr + k) % NREQ]) begin m_cur = (m_ptr + k) % NREQ; break; end
            end
            lv = req_load[m_cur*CNT_W +: CNT_W];
            m_L = longint'(lv);
            m_active = 1'b1;
            m_t = 0;
        end
        if (m_active)
            m_cnt = (m_t == 0) ? m_L : ((m_t <= m_L + 1) ? m_L - (m_t - 1) : 0);
    endtask

    task automatic step();
        @(posedge n0);
        cyc++;
        model_edge();
        #1;
        check_eq("gnt", 64'(gnt), 64'(exp_gnt()));
        check_eq("done", 64'(done), 64'(exp_done()));
        check_eq("busy", 64'(busy), 64'(m_active));
        check_eq("cur_idx", 64'(cur_idx), 64'(m_cur));
        check_eq("cnt_val", 64'(cnt_val), 64'(m_cnt));
        if (gnt != '0) last_gnt_cyc = cyc;
        if (done != '0) last_done_cyc = cyc;
        done_seen += $countones(done);
        if (auto_drop) req = req & ~exp_gnt();
    endtask

    task automatic set_load(input int i, input logic [CNT_W-1:0] v);
        req_load[i*CNT_W +: CNT_W] = v;
    endtask

    task automatic do_reset();
        n1 = 1'b1; step(); n1 = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((m_active || req != '0) && n < 2000) begin step(); n++; end
        if (n >= 2000) bound_expired("drain");
    endtask

    // Single job on requester i with delay L; returns gnt-to-done latency.
    task automatic measure_job(input int i, input logic [CNT_W-1:0] L, output int lat);
        int n;
        set_load(i, L);
        last_gnt_cyc = -1; last_done_cyc = -1;
        req = NREQ'(1 << i);
        n = 0;
        while (last_done_cyc < 0 && n < 200) begin step(); n++; end
        if (n >= 200) bound_expired("job_done");
        lat = last_done_cyc - last_gnt_cyc;
        drain();
    endtask

    initial begin
        int lat, n, d0, d1;
        int gq[$];
        int dq[$];

        // 1: reset then idle
        do_reset(); n1 = 1'b1; step(); n1 = 1'b0;
        for (int i = 0; i < 20; i++) step();

        // 2: single job L=5
        measure_job(0, 32'd5, lat);
        check_eq("lat_L5", 64'(lat), 64'd7);

        // 3: round robin with all requests held, L=0
        do_reset();
        for (int i = 0; i < NREQ; i++) set_load(i, '0);
        auto_drop = 1'b0;
        req = '1;
        n = 0;
        while (dq.size() < 5 && n < 60) begin
            step(); n++;
            for (int i = 0; i < NREQ; i++) if (gnt[i]) gq.push_back(i);
            if (done != '0) dq.push_back(cyc);
        end
        if (n >= 60) bound_expired("rr_jobs");
        req = '0;
        auto_drop = 1'b1;
        drain();
        for (int i = 0; i < 5; i++) check_eq("rr_order", 64'(gq[i]), 64'(i % NREQ));
        for (int i = 1; i < 5; i++) check_eq("rr_spacing", 64'(dq[i] - dq[i-1]), 64'd4);

        // 4: abort at cnt_val=40, then next grant goes to requester 3
        do_reset();
        set_load(2, 32'd100);
        req = 4'b0100;
        d0 = done_seen;
        n = 0;
        while (!(m_active && m_t >= 1 && m_cnt == 40) && n < 200) begin step(); n++; end
        if (n >= 200) bound_expired("reach_40");
        abort = 1'b1; step(); abort = 1'b0;
        check_eq("abort_busy", 64'(busy), 64'd0);
        check_eq("abort_hold", 64'(cnt_val), 64'd40);
        check_eq("abort_nodone", 64'(done_seen - d0), 64'd0);
        for (int i = 0; i < NREQ; i++) set_load(i, 32'd2);
        req = 4'b1111;
        step();
        check_eq("after_abort_gnt", 64'(gnt), 64'b1000);
        drain();

        // 5: reset mid-count
        do_reset();
        set_load(1, 32'd50);
        req = 4'b0010;
        n = 0;
        while (!(m_active && m_t >= 1 && m_cnt == 10) && n < 200) begin step(); n++; end
        if (n >= 200) bound_expired("reach_10");
        d0 = done_seen;
        n1 = 1'b1; step(); n1 = 1'b0;
        check_eq("rst_cnt", 64'(cnt_val), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 60; i++) step();
        check_eq("rst_nodone", 64'(done_seen - d0), 64'd0);

        // 6: edge values
        measure_job(2, 32'd0, lat);
        check_eq("lat_L0", 64'(lat), 64'd2);
        set_load(3, 32'hFFFF_FFFF);
        req = 4'b1000;
        step();
        check_eq("max_load", 64'(cnt_val), 64'hFFFF_FFFF);
        step(); step();
        check_eq("max_dec", 64'(cnt_val), 64'hFFFF_FFFE);
        abort = 1'b1; step(); abort = 1'b0;
        set_load(0, 32'd3);
        req = 4'b0001;
        n = 0;
        while (!(m_active && m_t == m_L + 1) && n < 50) begin step(); n++; end
        if (n >= 50) bound_expired("reach_zero");
        d1 = done_seen;
        abort = 1'b1; step(); abort = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check_eq("abort_at_zero", 64'(done_seen - d1), 64'd0);

        // random phase
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && $urandom_range(0, 3) == 0) begin
                    set_load(i, CNT_W'($urandom_range(0, 6)));
                    req[i] = 1'b1;
                end
            end
            abort = ($urandom_range(0, 9) == 0);
            n1 = ($urandom_range(0, 199) == 0);
            step();
        end
        abort = 1'b0; n1 = 1'b0; req = '0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
